// File: rtl/ahb_sram_arbiter.sv
// Two-master arbiter in front of the single-port AHB test SRAM.
// M1 (data) has fixed priority; M0 (fetch) is force-granted once it has waited WAIT_MAX cycles.
module ahb_sram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 3
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              m0_hsel,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_hrdata,
  input  logic              m1_hsel,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              s_hsel,
  output logic [ADDR_W-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  logic [3:0] wcnt_q, wcnt_d;
  logic       force0_q, force0_d;
  logic       dp_valid_q, dp_valid_d;
  logic       dp_owner_q, dp_owner_d;
  logic       dp_write_q, dp_write_d;
  logic       gnt0, gnt1;

  // Reset gates the grants directly so the slave is released without waiting for a clock.
  always_comb begin
    gnt1 = m1_hsel & s_hready & ~force0_q & ~HRESET;
    gnt0 = m0_hsel & s_hready & (~m1_hsel | force0_q) & ~HRESET;

    wcnt_d = 4'd0;
    if (m0_hsel && !gnt0) begin
      wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
    end
    force0_d = (wcnt_d >= WAIT_LIM);

    dp_valid_d = gnt0 | gnt1;
    dp_owner_d = gnt1;
    dp_write_d = (gnt0 & m0_hwrite) | (gnt1 & m1_hwrite);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wcnt_q     <= 4'd0;
      force0_q   <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
      dp_write_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      force0_q   <= force0_d;
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      dp_write_q <= dp_write_d;
    end
  end

  assign m0_hready = gnt0;
  assign m1_hready = gnt1;

  // With no grant the address mux parks on M0 so the slave inputs stay deterministic.
  assign s_hsel   = gnt0 | gnt1;
  assign s_haddr  = gnt1 ? m1_haddr : m0_haddr;
  assign s_hwrite = ~HRESET & (gnt1 ? m1_hwrite : m0_hwrite);

  // Data phase follows the registered owner, not the current grant.
  assign s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_rvalid = dp_valid_q & ~dp_write_q & ~dp_owner_q;
  assign m1_rvalid = dp_valid_q & ~dp_write_q & dp_owner_q;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Self-checking bench for ahb_sram_arbiter: directed test-plan steps followed by
// randomized traffic, checked against a transaction-level model of the arbitration rules.
module tb_ahb_sram_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int WAIT_MAX = 3;

  logic          HCLK;
  logic          HRESET;
  logic          m0_hsel, m0_hwrite, m0_hready, m0_rvalid;
  logic [AW-1:0] m0_haddr;
  logic [DW-1:0] m0_hwdata, m0_hrdata;
  logic          m1_hsel, m1_hwrite, m1_hready, m1_rvalid;
  logic [AW-1:0] m1_haddr;
  logic [DW-1:0] m1_hwdata, m1_hrdata;
  logic          s_hsel, s_hwrite, s_hready;
  logic [AW-1:0] s_haddr;
  logic [DW-1:0] s_hwdata, s_hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_rvalid(m0_rvalid), .m0_hrdata(m0_hrdata),
    .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_rvalid(m1_rvalid), .m1_hrdata(m1_hrdata),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Contents the SRAM holds after every reset (0x100 holds 0xDEADBEEF)
  function automatic logic [31:0] init_word(int i);
    return (i == 64) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
  endfunction

  // SRAM slave: 256 words, one-cycle data phase
  logic [31:0] sram_mem [0:255];
  logic        sram_dp_valid, sram_dp_write;
  logic [7:0]  sram_dp_idx;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
      sram_dp_valid <= 1'b0;
      sram_dp_write <= 1'b0;
      sram_dp_idx   <= 8'd0;
    end else begin
      if (sram_dp_valid && sram_dp_write) sram_mem[sram_dp_idx] <= s_hwdata;
      sram_dp_valid <= s_hsel & s_hready;
      sram_dp_write <= s_hwrite;
      sram_dp_idx   <= s_haddr[9:2];
    end
  end

  assign s_hrdata = sram_mem[sram_dp_idx];

  // Reference model: wait count of M0, the transfer now in its data phase, and memory image
  int          wait0;
  bit          md_valid, md_owner, md_write;
  logic [7:0]  md_idx;
  logic [31:0] ref_mem [0:255];
  bit          exp_g0, exp_g1;

  task automatic model_reset();
    wait0    = 0;
    md_valid = 0;
    md_owner = 0;
    md_write = 0;
    md_idx   = 8'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
  endtask

  task automatic applyStimulus(input bit s0, input logic [31:0] a0, input bit w0,
                               input bit s1, input logic [31:0] a1, input bit w1,
                               input bit rdy);
    m0_hsel   = s0;
    m0_haddr  = a0;
    m0_hwrite = w0;
    m1_hsel   = s1;
    m1_haddr  = a1;
    m1_hwrite = w1;
    s_hready  = rdy;
  endtask

  // Compare every observable output with what the model predicts for this cycle
  task automatic checkModel();
    bit starving;
    starving = (wait0 >= WAIT_MAX);
    exp_g1 = !HRESET && m1_hsel && s_hready && !starving;
    exp_g0 = !HRESET && m0_hsel && s_hready && (!m1_hsel || starving);
    checkOutput("m0_hready", {31'b0, m0_hready}, {31'b0, exp_g0});
    checkOutput("m1_hready", {31'b0, m1_hready}, {31'b0, exp_g1});
    checkOutput("s_hsel", {31'b0, s_hsel}, {31'b0, exp_g0 | exp_g1});
    if (exp_g0 || exp_g1) begin
      checkOutput("s_haddr", s_haddr, exp_g1 ? m1_haddr : m0_haddr);
      checkOutput("s_hwrite", {31'b0, s_hwrite}, {31'b0, exp_g1 ? m1_hwrite : m0_hwrite});
    end
    checkOutput("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, md_valid & !md_write & !md_owner});
    checkOutput("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, md_valid & !md_write & md_owner});
    if (md_valid && !md_write) begin
      checkOutput(md_owner ? "m1_hrdata" : "m0_hrdata",
                  md_owner ? m1_hrdata : m0_hrdata, ref_mem[md_idx]);
    end
    if (md_valid && md_write) begin
      checkOutput("s_hwdata", s_hwdata, md_owner ? m1_hwdata : m0_hwdata);
    end
  endtask

  task automatic updateModel();
    if (HRESET) begin
      model_reset();
    end else begin
      if (md_valid && md_write) ref_mem[md_idx] = md_owner ? m1_hwdata : m0_hwdata;
      md_valid = exp_g0 | exp_g1;
      md_owner = exp_g1;
      md_write = exp_g1 ? m1_hwrite : m0_hwrite;
      md_idx   = exp_g1 ? m1_haddr[9:2] : m0_haddr[9:2];
      if (m0_hsel && !exp_g0) wait0 = (wait0 < 15) ? wait0 + 1 : 15;
      else wait0 = 0;
    end
  endtask

  task automatic settle();
    #1;
    checkModel();
  endtask

  task automatic tick();
    @(posedge HCLK);
    updateModel();
    @(negedge HCLK);
  endtask

  bit          gnt0_pat [10];
  bit          p0, p1, w0r, w1r;
  logic [31:0] a0r, a1r;

  initial begin
    HRESET    = 1'b1;
    m0_hwdata = '0;
    m1_hwdata = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    model_reset();
    repeat (2) @(negedge HCLK);

    // Reset state, with both masters requesting
    applyStimulus(1, 32'h10, 1, 1, 32'h20, 1, 1);
    #1;
    checkOutput("rst_s_hsel", {31'b0, s_hsel}, 32'd0);
    checkOutput("rst_m0_hready", {31'b0, m0_hready}, 32'd0);
    checkOutput("rst_m1_hready", {31'b0, m1_hready}, 32'd0);
    checkOutput("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    checkOutput("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    checkOutput("rst_s_hwrite", {31'b0, s_hwrite}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle(); tick();

    // Single M0 read of 0x100
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t1_hready", {31'b0, m0_hready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t1_rvalid", {31'b0, m0_rvalid}, 32'd1);
    checkOutput("t1_rdata", m0_hrdata, 32'hDEADBEEF);
    checkOutput("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    tick();

    // M1 write 0x40 then M0 read 0x40
    applyStimulus(0, 0, 0, 1, 32'h40, 1, 1);
    settle(); tick();
    m1_hwdata = 32'h12345678;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t2_hwdata", s_hwdata, 32'h12345678);
    tick();
    m1_hwdata = 32'h0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t2_rvalid", {31'b0, m0_rvalid}, 32'd1);
    checkOutput("t2_rdata", m0_hrdata, 32'h12345678);
    tick();

    // Continuous contention: M1,M1,M1,M0 repeating
    gnt0_pat = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h100, 0, 1, 32'h100 + 32'(4 * i), 0, 1);
      settle();
      checkOutput("t3_gnt0", {31'b0, m0_hready}, {31'b0, gnt0_pat[i]});
      checkOutput("t3_gnt1", {31'b0, m1_hready}, {31'b0, !gnt0_pat[i]});
      tick();
      if (gnt0_pat[i]) checkOutput("t3_wcnt", {28'b0, dut.wcnt_q}, 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle(); tick();

    // Alternating M0 reads and M1 writes, no contention
    for (int i = 0; i < 8; i++) begin
      m1_hwdata = 32'hC0DE0000 + 32'(i - 1);
      if (i % 2 == 0) applyStimulus(1, 32'h80 + 32'(4 * i), 0, 0, 0, 0, 1);
      else            applyStimulus(0, 0, 0, 1, 32'h80 + 32'(4 * i), 1, 1);
      settle();
      checkOutput("t4_accept", {31'b0, (i % 2 == 0) ? m0_hready : m1_hready}, 32'd1);
      if (i % 2 == 0 && i > 0) checkOutput("t4_hwdata", s_hwdata, 32'hC0DE0000 + 32'(i - 1));
      if (i % 2 == 1) checkOutput("t4_rvalid", {31'b0, m0_rvalid}, 32'd1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle(); tick();

    // Reset in the middle of an M1 read data phase
    applyStimulus(0, 0, 0, 1, 32'h100, 0, 1);
    settle(); tick();
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 1);
    settle();
    #1;
    HRESET = 1'b1;
    model_reset();
    #1;
    checkOutput("t5_s_hsel", {31'b0, s_hsel}, 32'd0);
    checkOutput("t5_m1_hready", {31'b0, m1_hready}, 32'd0);
    checkOutput("t5_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'h100, 0, 1);
    settle();
    checkOutput("t5_re_hready", {31'b0, m1_hready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t5_re_rvalid", {31'b0, m1_rvalid}, 32'd1);
    checkOutput("t5_re_rdata", m1_hrdata, 32'hDEADBEEF);
    tick();

    // Slave stall with M0 pending
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h200, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t6_stall_hready", {31'b0, m0_hready}, 32'd0);
      checkOutput("t6_stall_s_hsel", {31'b0, s_hsel}, 32'd0);
      tick();
    end
    applyStimulus(1, 32'h200, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t6_release", {31'b0, m0_hready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle(); tick();

    // Randomized traffic; each master holds its request until accepted
    p0 = 0; p1 = 0; a0r = 0; a1r = 0; w0r = 0; w1r = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; a0r = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; w0r = 1'($urandom_range(0, 1));
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; a1r = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; w1r = 1'($urandom_range(0, 1));
      end
      m0_hwdata = $urandom;
      m1_hwdata = $urandom;
      applyStimulus(p0, a0r, w0r, p1, a1r, w1r, $urandom_range(0, 7) != 0);
      settle();
      if (exp_g0) p0 = 0;
      if (exp_g1) p1 = 0;
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    settle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_arbiter.md
Name: ahb_sram_arbiter

Overview:
- Two-master arbiter sharing the single-port AHB test SRAM between the instruction-fetch master (M0) and the data master (M1).
- Fixed priority to M1, with a starvation counter that forces a grant to M0 after a bounded wait.
- Tracks the one-cycle SRAM data phase so that write data and read data are routed to the correct master.
- Sits between the core's two bus ports and the SRAM slave port.

Parameters:
- ADDR_W, 32, address width (matches AHB_ADDR_WIDTH).
- DATA_W, 32, data width (matches AHB_DATA_WIDTH).
- WAIT_MAX, 3, consecutive M0 wait cycles tolerated before M0 is force-granted; legal range 1..15.

Ports:
- HCLK  in  1  single clock; all state updates on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- m0_hsel  in  1  M0 request (address phase valid).
- m0_haddr  in  ADDR_W  M0 address.
- m0_hwrite  in  1  M0 write=1 / read=0.
- m0_hwdata  in  DATA_W  M0 write data, driven in the cycle after acceptance.
- m0_hready  out  1  M0 address accepted this cycle.
- m0_rvalid  out  1  m0_hrdata valid this cycle.
- m0_hrdata  out  DATA_W  M0 read data.
- m1_* : same seven ports for M1.
- s_hsel  out  1  to SRAM HSEL.
- s_haddr  out  ADDR_W  to SRAM HADDR.
- s_hwrite  out  1  to SRAM HWRITE.
- s_hwdata  out  DATA_W  to SRAM HWDATA.
- s_hrdata  in  DATA_W  from SRAM HRDATA.
- s_hready  in  1  from SRAM HREADY; the SRAM ties it to 1, but it is honoured anyway.

Behaviour:
- Master protocol:
  - A master asserts hsel with haddr/hwrite and holds all three stable until it sees hready=1 in the same cycle.
  - A write master drives hwdata in the cycle after acceptance.
  - A read master samples hrdata in the cycle after acceptance, when rvalid=1.
- Grant is combinational from the requests and the registered state:
  - gnt1 = m1_hsel & s_hready & ~force0
  - gnt0 = m0_hsel & s_hready & (~m1_hsel | force0)
  - At most one grant is active per cycle.
- mX_hready = gntX; it is 0 whenever mX_hsel=0.
- Slave address mux:
  - s_hsel = gnt0 | gnt1.
  - s_haddr/s_hwrite come from the granted master.
  - With no grant, s_haddr/s_hwrite hold the M0 values (don't-care, but deterministic).
- Starvation counter wcnt (4 bits):
  - If m0_hsel & ~gnt0, wcnt increments (saturating at 15).
  - If gnt0 or ~m0_hsel, wcnt clears.
  - force0 = (wcnt >= WAIT_MAX), a registered compare.
  - A forced grant lasts exactly one cycle, then wcnt=0 and M1 priority resumes.
- Data-phase register, updated each clock:
  - dp_valid <= gnt0|gnt1; dp_owner <= gnt1; dp_write <= granted hwrite.
- Data-phase routing:
  - s_hwdata = dp_owner ? m1_hwdata : m0_hwdata.
  - m0_hrdata = m1_hrdata = s_hrdata (broadcast).
  - m0_rvalid = dp_valid & ~dp_write & ~dp_owner.
  - m1_rvalid = dp_valid & ~dp_write & dp_owner.
- Latency:
  - Read data arrives 1 cycle after acceptance.
  - Write data is consumed 1 cycle after acceptance.
  - Back-to-back accesses from either master are accepted every cycle; address and data phases overlap.
- Switching owners between consecutive cycles costs no bubble; the data-phase owner is independent of the current grant.
- HRESET asserted, at any time:
  - All grants forced to 0 asynchronously: s_hsel=0, m0_hready=m1_hready=0.
  - wcnt, dp_valid, dp_owner and dp_write clear immediately; rvalid=0.
  - An in-flight data phase is dropped; masters must reissue after reset.
- After HRESET deasserts, arbitration is valid on the first rising edge.
- s_hready=0: no grant is issued and wcnt still counts for a waiting M0.
- Simultaneous request with force0=1: M0 wins and M1 sees hready=0 for that cycle.
- Reset values: all outputs 0 except the mux outputs s_haddr, s_hwdata and mX_hrdata, which follow inputs combinationally.

Test Plan:
- Single M0 read of addr 0x100 (preloaded 0xDEADBEEF), M1 idle:
  - m0_hready=1 in cycle N.
  - m0_rvalid=1 with m0_hrdata=0xDEADBEEF in N+1.
  - m1_rvalid=0 throughout.
- M1 write 0x0000_0040 <- 0x12345678 in cycle N, then M0 read 0x40 in N+1:
  - s_hwdata=0x12345678 in N+1, selected from m1_hwdata.
  - m0_hrdata=0x12345678 in N+2.
- Both masters request continuously for 10 cycles, WAIT_MAX=3:
  - Grant pattern is M1,M1,M1,M0,M1,M1,M1,M0,M1,M1.
  - wcnt returns to 0 after each M0 grant.
- Alternate-cycle M0 reads and M1 writes with no contention:
  - Every request is accepted in its first cycle.
  - Each rvalid/hwdata routes to the correct owner with zero bubbles.
- Assert HRESET mid data phase of an M1 read:
  - s_hsel, m1_hready and m1_rvalid drop to 0 without waiting for a clock edge.
  - After release, a new M1 read completes normally with correct data.
- Drive s_hready=0 for 4 cycles with M0 pending and M1 idle:
  - No grant is issued.
  - M0 is granted on the first cycle s_hready=1.
